alu_sequencer: RTL and testbench

//  Multi-cycle control unit for the 8-bit combinational ALU: fetches instruction words from a

---
 rtl/alu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute control unit for the 8-bit
// combinational ALU. It fetches 16-bit words from a synchronous program ROM,
// drives the ALU with ACC and one register-file entry, and writes results back
// to ACC, the register file and a latched flag register.
//
// Instruction word: [15:10] opcode, [9:8] reserved, [7:0] operand/immediate.
// Opcode encoding (shared with the ALU):
//   NOP 00  LDI 01  LDR 02  STR 03  JMP 04  JZ 05  JC 06  HLT 07
//   ADD 10  SUB 11  AND 12  OR 13   XOR 14  NOT 15 INC 16 DEC 17 RL 18 RR 19
// Any unlisted opcode behaves as NOP.
module alu_sequencer #(
  parameter int PC_W  = 8,
  parameter int RF_AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  output logic [5:0]      alu_instr_code,
  output logic [7:0]      alu_in_data,
  output logic [7:0]      alu_reg_file,
  input  logic [7:0]      alu_result,
  input  logic            alu_flag_z,
  input  logic            alu_flag_cy,
  input  logic            alu_flag_s,
  input  logic            alu_flag_p,
  output logic [7:0]      acc,
  output logic [4:0]      flags,
  output logic            halted
);

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_LDI = 6'h01;
  localparam logic [5:0] OP_LDR = 6'h02;
  localparam logic [5:0] OP_STR = 6'h03;
  localparam logic [5:0] OP_JMP = 6'h04;
  localparam logic [5:0] OP_JZ  = 6'h05;
  localparam logic [5:0] OP_JC  = 6'h06;
  localparam logic [5:0] OP_HLT = 6'h07;
  localparam logic [5:0] OP_ADD = 6'h10;
  localparam logic [5:0] OP_SUB = 6'h11;
  localparam logic [5:0] OP_AND = 6'h12;
  localparam logic [5:0] OP_OR  = 6'h13;
  localparam logic [5:0] OP_XOR = 6'h14;
  localparam logic [5:0] OP_NOT = 6'h15;
  localparam logic [5:0] OP_INC = 6'h16;
  localparam logic [5:0] OP_DEC = 6'h17;
  localparam logic [5:0] OP_RL  = 6'h18;
  localparam logic [5:0] OP_RR  = 6'h19;

  localparam int RF_N = 2**RF_AW;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  // Decoded control for the instruction held in IR.
  typedef struct packed {
    logic alu_op;   // ACC <= ALU result, z/s/p updated
    logic is_add;   // carry flag also updated
    logic ld_imm;   // ACC <= immediate
    logic ld_reg;   // ACC <= RF[n]
    logic st_reg;   // RF[n] <= ACC
    logic jmp;      // unconditional jump
    logic jz;       // jump if latched z
    logic jc;       // jump if latched cy
    logic hlt;      // enter HALT after this EXECUTE
  } ctl_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc;
  logic [5:0]        ir_op;
  logic [7:0]        ir_opnd;
  logic [7:0]        rf [RF_N];
  logic              flag_z, flag_cy, flag_s, flag_p;
  ctl_t              ctl;
  logic              take_jump;
  logic [RF_AW-1:0]  rf_idx;
  logic              unused_rsvd;

  // Reserved instruction bits are architecturally ignored.
  assign unused_rsvd = ^prog_data[9:8];

  assign rf_idx         = ir_opnd[RF_AW-1:0];
  assign prog_addr      = pc;
  assign alu_instr_code = ir_op;
  assign alu_in_data    = acc;
  assign alu_reg_file   = rf[rf_idx];
  assign flags          = {flag_s, flag_p, 1'b0, flag_cy, flag_z};
  assign halted         = (state == S_HALT);

  // Opcode decode; unknown opcodes fall through as all-zero control (NOP).
  always_comb begin
    ctl = '0;
    unique case (ir_op)
      OP_LDI: ctl.ld_imm = 1'b1;
      OP_LDR: ctl.ld_reg = 1'b1;
      OP_STR: ctl.st_reg = 1'b1;
      OP_JMP: ctl.jmp    = 1'b1;
      OP_JZ:  ctl.jz     = 1'b1;
      OP_JC:  ctl.jc     = 1'b1;
      OP_HLT: ctl.hlt    = 1'b1;
      OP_ADD: begin
        ctl.alu_op = 1'b1;
        ctl.is_add = 1'b1;
      end
      OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_INC, OP_DEC, OP_RL, OP_RR: ctl.alu_op = 1'b1;
      default: ctl = '0;
    endcase
  end

  // Conditional jumps look at flags latched before this instruction.
  assign take_jump = ctl.jmp | (ctl.jz & flag_z) | (ctl.jc & flag_cy);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // FSM next-state: FETCH stalls on !run, HALT is terminal until reset.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:   if (run) state_nx = S_DECODE;
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: state_nx = ctl.hlt ? S_HALT : S_FETCH;
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_FETCH;
    endcase
  end

  // PC and IR: latch ROM word and advance in DECODE, redirect on a taken jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir_op   <= '0;
      ir_opnd <= '0;
    end else if (state == S_DECODE) begin
      ir_op   <= prog_data[15:10];
      ir_opnd <= prog_data[7:0];
      pc      <= pc + 1'b1;
    end else if (state == S_EXECUTE && take_jump) begin
      pc      <= PC_W'(ir_opnd);
    end
  end

  // ACC and flags written back at the end of EXECUTE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      flag_z  <= 1'b0;
      flag_cy <= 1'b0;
      flag_s  <= 1'b0;
      flag_p  <= 1'b0;
    end else if (state == S_EXECUTE) begin
      if (ctl.alu_op) begin
        acc    <= alu_result;
        flag_z <= alu_flag_z;
        flag_s <= alu_flag_s;
        flag_p <= alu_flag_p;
        if (ctl.is_add) flag_cy <= alu_flag_cy;
      end else if (ctl.ld_imm) begin
        acc <= ir_opnd;
      end else if (ctl.ld_reg) begin
        acc <= rf[rf_idx];
      end
    end
  end

  // Register file: cleared on reset, written by STR at the end of EXECUTE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_N; i++) rf[i] <= '0;
    end else if (state == S_EXECUTE && ctl.st_reg) begin
      rf[rf_idx] <= acc;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ROM and ALU sit beside the
// DUT; expected values are queued per scenario and popped at each check point.
module tb_alu_sequencer;

  localparam logic [5:0] NOP = 6'h00, LDI = 6'h01, LDR = 6'h02, STR = 6'h03;
  localparam logic [5:0] JMP = 6'h04, JZ  = 6'h05, JC  = 6'h06, HLT = 6'h07;
  localparam logic [5:0] ADD = 6'h10, SUB = 6'h11, ANDO = 6'h12, ORO = 6'h13;
  localparam logic [5:0] XORO = 6'h14, NOTO = 6'h15, INC = 6'h16, DEC = 6'h17;
  localparam logic [5:0] RL  = 6'h18, RR  = 6'h19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data = '0;
  logic [5:0]  alu_instr_code;
  logic [7:0]  alu_in_data, alu_reg_file, alu_result;
  logic        alu_flag_z, alu_flag_cy, alu_flag_s, alu_flag_p;
  logic [7:0]  acc;
  logic [4:0]  flags;
  logic        halted;

  alu_sequencer #(.PC_W(8), .RF_AW(3)) dut (
    .clk(clk), .rst(rst), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .alu_instr_code(alu_instr_code), .alu_in_data(alu_in_data),
    .alu_reg_file(alu_reg_file), .alu_result(alu_result),
    .alu_flag_z(alu_flag_z), .alu_flag_cy(alu_flag_cy),
    .alu_flag_s(alu_flag_s), .alu_flag_p(alu_flag_p),
    .acc(acc), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM.
  logic [15:0] rom [256];
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Reference combinational ALU.
  logic [7:0] a_res;
  logic       a_cy;
  always_comb begin
    a_res = alu_in_data;
    a_cy  = 1'b0;
    case (alu_instr_code)
      ADD:  {a_cy, a_res} = {1'b0, alu_in_data} + {1'b0, alu_reg_file};
      SUB:  {a_cy, a_res} = {1'b0, alu_in_data} - {1'b0, alu_reg_file};
      ANDO: a_res = alu_in_data & alu_reg_file;
      ORO:  a_res = alu_in_data | alu_reg_file;
      XORO: a_res = alu_in_data ^ alu_reg_file;
      NOTO: a_res = ~alu_in_data;
      INC:  {a_cy, a_res} = {1'b0, alu_in_data} + 9'd1;
      DEC:  {a_cy, a_res} = {1'b0, alu_in_data} - 9'd1;
      RL:   {a_cy, a_res} = {alu_in_data, 1'b0};
      RR:   {a_res, a_cy} = {1'b0, alu_in_data};
      default: a_res = alu_in_data;
    endcase
  end
  assign alu_result  = a_res;
  assign alu_flag_z  = (a_res == 8'h00);
  assign alu_flag_cy = a_cy;
  assign alu_flag_s  = a_res[7];
  assign alu_flag_p  = ~^a_res;

  // Scoreboard.
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb [$];
  int total  = 0;
  int passed = 0;

  function automatic logic [15:0] ins(input logic [5:0] op, input logic [7:0] v);
    return {op, 2'b00, v};
  endfunction

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0h required=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(NOP, 8'h00);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int maxc, output int n);
    n = 0;
    while (halted !== 1'b1 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    // ---- Reset state + basic program: LDI 5; STR r1; LDI 3; ADD r1; HLT
    clear_rom();
    rom[0] = ins(LDI, 8'h05); rom[1] = ins(STR, 8'h01);
    rom[2] = ins(LDI, 8'h03); rom[3] = ins(ADD, 8'h01);
    rom[4] = ins(HLT, 8'h00);
    expect_v("rst_prog_addr", 0); expect_v("rst_acc", 0);
    expect_v("rst_flags", 0);     expect_v("rst_halted", 0);
    expect_v("rst_instr_code", 0);
    expect_v("t1_halt_cycle", 15); expect_v("t1_halted", 1);
    expect_v("t1_acc", 8'h08);     expect_v("t1_flags", 5'b00000);
    expect_v("t1_prog_addr", 5);   expect_v("t1_frozen_addr", 5);
    expect_v("t1_frozen_acc", 8'h08);
    @(negedge clk);
    rst = 1'b1; run = 1'b1;
    #1;
    check(prog_addr); check(acc); check(flags); check(halted); check(alu_instr_code);
    @(negedge clk);
    rst = 1'b0;
    wait_halt(40, n);
    check(n); check(halted); check(acc); check(flags); check(prog_addr);
    run = 1'b0; step(3); run = 1'b1; step(3);
    check(prog_addr); check(acc);

    // ---- ADD overflow to zero, then JZ taken
    clear_rom();
    rom[0] = ins(LDI, 8'hFF); rom[1] = ins(STR, 8'h02);
    rom[2] = ins(LDI, 8'h01); rom[3] = ins(ADD, 8'h02);
    rom[4] = ins(JZ, 8'h20);  rom[5] = ins(LDI, 8'h99);
    rom[8'h20] = ins(HLT, 8'h00);
    expect_v("t2_add_acc", 8'h00); expect_v("t2_add_flags", 5'b01011);
    expect_v("t2_jz_pc", 8'h20);
    expect_v("t2_halted", 1); expect_v("t2_acc", 8'h00); expect_v("t2_prog_addr", 8'h21);
    reset_pulse();
    step(12);
    check(acc); check(flags);
    step(3);
    check(prog_addr);
    wait_halt(20, n);
    check(halted); check(acc); check(prog_addr);

    // ---- RL to zero: cy from ALU not latched, JC not taken
    clear_rom();
    rom[0] = ins(LDI, 8'h80); rom[1] = ins(RL, 8'h00);
    rom[2] = ins(JC, 8'h10);  rom[3] = ins(HLT, 8'h00);
    rom[8'h10] = ins(LDI, 8'h77); rom[8'h11] = ins(HLT, 8'h00);
    expect_v("t3_halted", 1); expect_v("t3_acc", 8'h00);
    expect_v("t3_flags", 5'b01001); expect_v("t3_prog_addr", 4);
    reset_pulse();
    wait_halt(30, n);
    check(halted); check(acc); check(flags); check(prog_addr);

    // ---- PC wrap from 0xFF to 0x00
    clear_rom();
    rom[0] = ins(JMP, 8'hFF); rom[8'hFF] = ins(NOP, 8'h00);
    expect_v("t4_jmp_pc", 8'hFF); expect_v("t4_wrap_pc", 8'h00);
    reset_pulse();
    step(3);
    check(prog_addr);
    step(3);
    check(prog_addr);

    // ---- Reset during EXECUTE of STR r3 (r3 already holds 0x5A)
    clear_rom();
    rom[0] = ins(LDI, 8'h5A); rom[1] = ins(STR, 8'h03);
    rom[2] = ins(LDI, 8'h66); rom[3] = ins(STR, 8'h03);
    expect_v("t5_pre_acc", 8'h66);
    expect_v("t5_rst_acc", 0); expect_v("t5_rst_pc", 0); expect_v("t5_rst_halted", 0);
    expect_v("t5_restart_cycles", 6); expect_v("t5_r3_cleared", 0);
    reset_pulse();
    step(11);
    check(acc);
    rst = 1'b1;
    #1;
    check(acc); check(prog_addr); check(halted);
    clear_rom();
    rom[0] = ins(LDR, 8'h03); rom[1] = ins(HLT, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_halt(20, n);
    check(n); check(acc);

    // ---- run stall in FETCH, run drop mid-instruction, HALT ignores run
    clear_rom();
    rom[0] = ins(LDI, 8'h11); rom[1] = ins(INC, 8'h00); rom[2] = ins(HLT, 8'h00);
    expect_v("t6_first_acc", 8'h11);
    for (int i = 0; i < 4; i++) expect_v($sformatf("t6_stall_pc%0d", i), 1);
    expect_v("t6_stall_acc", 8'h11);
    expect_v("t6_mid_acc", 8'h12); expect_v("t6_mid_pc", 2); expect_v("t6_mid_halted", 0);
    expect_v("t6_halted", 1); expect_v("t6_flags", 5'b01000);
    expect_v("t6_halt_pc", 3); expect_v("t6_halt_acc", 8'h12);
    reset_pulse();
    step(3);
    check(acc);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check(prog_addr);
    end
    check(acc);
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(2);
    check(acc); check(prog_addr);
    step(2);
    check(halted);
    run = 1'b1;
    wait_halt(10, n);
    check(halted); check(flags);
    run = 1'b0; step(2); run = 1'b1; step(4);
    check(prog_addr); check(acc);

    // ---- STR then LDR to the same register in back-to-back instructions
    clear_rom();
    rom[0] = ins(LDI, 8'h3C); rom[1] = ins(STR, 8'h05);
    rom[2] = ins(LDI, 8'h00); rom[3] = ins(LDR, 8'h05);
    rom[4] = ins(HLT, 8'h00);
    expect_v("t7_str_ldr_acc", 8'h3C); expect_v("t7_flags", 0);
    reset_pulse();
    wait_halt(30, n);
    check(acc); check(flags);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
